// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares N common-data-bus lanes among NUM_REQ completing
// functional units (ALU, MULT, LOAD; index order fixed by top-level wiring).
//
// Each cycle up to N valid requesters are granted. Starving requesters
// (age >= STARVE_LIMIT) are granted first, lowest index first. Any lanes
// left over are filled round-robin from rr_ptr. Granted payloads are
// registered onto the CDB lanes at the next edge.
//
// Handshake: a requester raises req_valid[i] and holds its payload stable
// until it sees grant[i] high at a posedge. At that edge the result is
// accepted, and the FU may drop or replace it. grant[i] is only ever
// asserted together with req_valid[i].
//
// Ports:
//   clock, reset_n        clock (posedge) and asynchronous active-low reset
//   squash                mispredict flush: no grants this cycle, lanes
//                         cleared and ages cleared at the next edge
//   req_valid/prn/value/robn  per-requester result, packed by index
//   grant                 combinational per-requester accept
//   cdb_valid/prn/value/robn/src  registered broadcast lanes
//   rr_ptr                current round-robin start index (observable state)
module cdb_arbiter #(
    parameter int NUM_REQ      = 8,
    parameter int N            = 2,
    parameter int PRN_W        = 6,
    parameter int ROBN_W       = 5,
    parameter int DATA_W       = 32,
    parameter int AGE_W        = 3,
    parameter int STARVE_LIMIT = 4,
    localparam int SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      squash,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*PRN_W-1:0]  req_prn,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    input  logic [NUM_REQ*ROBN_W-1:0] req_robn,
    output logic [NUM_REQ-1:0]        grant,
    output logic [N-1:0]              cdb_valid,
    output logic [N*PRN_W-1:0]        cdb_prn,
    output logic [N*DATA_W-1:0]       cdb_value,
    output logic [N*ROBN_W-1:0]       cdb_robn,
    output logic [N*SRC_W-1:0]        cdb_src,
    output logic [SRC_W-1:0]          rr_ptr
);

    logic [AGE_W-1:0]     age [NUM_REQ];
    logic [NUM_REQ-1:0]   sel;          // raw selection before squash/reset gating
    logic [NUM_REQ-1:0]   p1;           // phase-1 (starvation) picks
    logic [2*NUM_REQ-1:0] avail2;       // leftover requests rotated so rr_ptr is bit 0
    logic [NUM_REQ-1:0]   p2_rot;       // phase-2 picks in rotated order
    logic [2*NUM_REQ-1:0] p2_wide;
    logic [N-1:0]         lane_used;
    logic [SRC_W-1:0]     lane_src [N];
    logic                 p2_any;
    logic [SRC_W-1:0]     rr_next;
    logic                 grant_en;

    always_comb begin
        int cnt;
        int idx;
        cnt       = 0;
        idx       = 0;
        p1        = '0;
        p2_rot    = '0;
        lane_used = '0;
        p2_any    = 1'b0;
        rr_next   = rr_ptr;
        for (int l = 0; l < N; l++) lane_src[l] = '0;

        // Phase 1: starving requesters, lowest index first, lowest lanes.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && age[i] >= AGE_W'(STARVE_LIMIT) && cnt < N) begin
                p1[i] = 1'b1;
                for (int l = 0; l < N; l++) begin
                    if (l == cnt) begin
                        lane_used[l] = 1'b1;
                        lane_src[l]  = SRC_W'(i);
                    end
                end
                cnt = cnt + 1;
            end
        end

        // Phase 2: cyclic scan from rr_ptr. Rotating the leftover request
        // vector keeps the scan a plain ascending loop.
        avail2 = {req_valid & ~p1, req_valid & ~p1} >> rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (avail2[k] && cnt < N) begin
                p2_rot[k] = 1'b1;
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                for (int l = 0; l < N; l++) begin
                    if (l == cnt) begin
                        lane_used[l] = 1'b1;
                        lane_src[l]  = SRC_W'(idx);
                    end
                end
                cnt     = cnt + 1;
                p2_any  = 1'b1;
                rr_next = (idx == NUM_REQ - 1) ? '0 : SRC_W'(idx + 1);
            end
        end

        // Rotate phase-2 picks back to requester index order.
        p2_wide = {p2_rot, p2_rot} << rr_ptr;
        sel     = p1 | p2_wide[2*NUM_REQ-1:NUM_REQ];
    end

    assign grant_en = reset_n && !squash;
    assign grant    = sel & {NUM_REQ{grant_en}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid <= '0;
            cdb_prn   <= '0;
            cdb_value <= '0;
            cdb_robn  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < NUM_REQ; i++) age[i] <= '0;
        end else begin
            // Lanes are rewritten every cycle; unused lanes read all zero.
            for (int l = 0; l < N; l++) begin
                if (lane_used[l] && !squash) begin
                    cdb_valid[l]                  <= 1'b1;
                    cdb_prn[l*PRN_W +: PRN_W]     <= req_prn[lane_src[l]*PRN_W +: PRN_W];
                    cdb_value[l*DATA_W +: DATA_W] <= req_value[lane_src[l]*DATA_W +: DATA_W];
                    cdb_robn[l*ROBN_W +: ROBN_W]  <= req_robn[lane_src[l]*ROBN_W +: ROBN_W];
                    cdb_src[l*SRC_W +: SRC_W]     <= lane_src[l];
                end else begin
                    cdb_valid[l]                  <= 1'b0;
                    cdb_prn[l*PRN_W +: PRN_W]     <= '0;
                    cdb_value[l*DATA_W +: DATA_W] <= '0;
                    cdb_robn[l*ROBN_W +: ROBN_W]  <= '0;
                    cdb_src[l*SRC_W +: SRC_W]     <= '0;
                end
            end
            // Pointer only moves on phase-2 grants; squash freezes it.
            if (p2_any && !squash) rr_ptr <= rr_next;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || grant[i] || squash) age[i] <= '0;
                else if (age[i] != {AGE_W{1'b1}})      age[i] <= age[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int NR = 8;
    localparam int N  = 2;
    localparam int PW = 6;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int SW = 3;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            squash = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*PW-1:0] req_prn;
    logic [NR*DW-1:0] req_value;
    logic [NR*RW-1:0] req_robn;
    logic [NR-1:0]   grant;
    logic [N-1:0]    cdb_valid;
    logic [N*PW-1:0] cdb_prn;
    logic [N*DW-1:0] cdb_value;
    logic [N*RW-1:0] cdb_robn;
    logic [N*SW-1:0] cdb_src;
    logic [SW-1:0]   rr_ptr;

    int n_checks = 0;
    int n_pass   = 0;

    cdb_arbiter #(
        .NUM_REQ(NR), .N(N), .PRN_W(PW), .ROBN_W(RW), .DATA_W(DW),
        .AGE_W(3), .STARVE_LIMIT(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .squash(squash),
        .req_valid(req_valid), .req_prn(req_prn), .req_value(req_value),
        .req_robn(req_robn), .grant(grant), .cdb_valid(cdb_valid),
        .cdb_prn(cdb_prn), .cdb_value(cdb_value), .cdb_robn(cdb_robn),
        .cdb_src(cdb_src), .rr_ptr(rr_ptr)
    );

    // ---- clock / watchdog ----
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    // ---- checking ----
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: act=%0h req=%0h @%0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic          sq;
        logic [NR-1:0] exp_grant;
        logic [N-1:0]  exp_cv;
        logic [SW-1:0] exp_s0;
        logic [SW-1:0] exp_s1;
        logic [SW-1:0] exp_rr;
    } vec_t;

    function automatic vec_t mk(input logic [NR-1:0] v, input logic s, input logic [NR-1:0] g,
                                input logic [N-1:0] cv, input int s0, input int s1, input int rr);
        vec_t r;
        r.valid = v; r.sq = s; r.exp_grant = g; r.exp_cv = cv;
        r.exp_s0 = SW'(s0); r.exp_s1 = SW'(s1); r.exp_rr = SW'(rr);
        return r;
    endfunction

    // Default payload: prn = idx+1, value = A000_0000+idx, robn = idx.
    task automatic load_payload();
        for (int i = 0; i < NR; i++) begin
            req_prn[i*PW +: PW]   = PW'(i + 1);
            req_value[i*DW +: DW] = 32'hA000_0000 + i;
            req_robn[i*RW +: RW]  = RW'(i);
        end
    endtask

    // Apply one vector: check grant before the edge, lanes/pointer after.
    task automatic run_vec(input vec_t v, input string tag);
        logic [PW-1:0] ep0, ep1;
        logic [DW-1:0] ev0;
        req_valid = v.valid;
        squash    = v.sq;
        #1;
        chk({tag, " grant"}, 64'(grant), 64'(v.exp_grant));
        @(posedge clock); #1;
        ep0 = v.exp_cv[0] ? PW'(v.exp_s0 + 1) : '0;
        ep1 = v.exp_cv[1] ? PW'(v.exp_s1 + 1) : '0;
        ev0 = v.exp_cv[0] ? 32'hA000_0000 + v.exp_s0 : '0;
        chk({tag, " cdb_valid"}, 64'(cdb_valid), 64'(v.exp_cv));
        chk({tag, " src0"}, 64'(cdb_src[0 +: SW]), 64'(v.exp_cv[0] ? v.exp_s0 : SW'(0)));
        chk({tag, " src1"}, 64'(cdb_src[SW +: SW]), 64'(v.exp_cv[1] ? v.exp_s1 : SW'(0)));
        chk({tag, " prn0"}, 64'(cdb_prn[0 +: PW]), 64'(ep0));
        chk({tag, " prn1"}, 64'(cdb_prn[PW +: PW]), 64'(ep1));
        chk({tag, " value0"}, 64'(cdb_value[0 +: DW]), 64'(ev0));
        chk({tag, " robn0"}, 64'(cdb_robn[0 +: RW]), 64'(v.exp_cv[0] ? RW'(v.exp_s0) : RW'(0)));
        chk({tag, " rr_ptr"}, 64'(rr_ptr), 64'(v.exp_rr));
    endtask

    vec_t tab1[$];
    vec_t tab2[$];

    initial begin
        // Hand-computed with STARVE_LIMIT=2.
        tab1.push_back(mk(8'b0000_0111, 0, 8'b0000_0011, 2'b11, 0, 1, 2)); // basic RR
        tab1.push_back(mk(8'b0000_0101, 0, 8'b0000_0101, 2'b11, 2, 0, 1)); // 2 held, 0 re-raised
        tab1.push_back(mk(8'b0100_0000, 0, 8'b0100_0000, 2'b01, 6, 0, 7)); // move ptr to 7
        tab1.push_back(mk(8'b1000_0010, 0, 8'b1000_0010, 2'b11, 7, 1, 2)); // wrap 7 -> 1
        tab1.push_back(mk(8'b0000_0000, 0, 8'b0000_0000, 2'b00, 0, 0, 2)); // idle
        tab1.push_back(mk(8'b0011_1000, 1, 8'b0000_0000, 2'b00, 0, 0, 2)); // squash
        tab1.push_back(mk(8'b0011_1000, 0, 8'b0001_1000, 2'b11, 3, 4, 5)); // resume
        tab1.push_back(mk(8'b0000_0000, 0, 8'b0000_0000, 2'b00, 0, 0, 5)); // idle
        // Starvation run, all valid from rr_ptr=0 with clear ages.
        tab2.push_back(mk(8'hFF, 0, 8'b0000_0011, 2'b11, 0, 1, 2));
        tab2.push_back(mk(8'hFF, 0, 8'b0000_1100, 2'b11, 2, 3, 4));
        tab2.push_back(mk(8'hFF, 0, 8'b0011_0000, 2'b11, 4, 5, 4)); // phase 1, ptr held
        tab2.push_back(mk(8'hFF, 0, 8'b0000_0011, 2'b11, 0, 1, 4)); // phase 1
        tab2.push_back(mk(8'hFF, 0, 8'b0000_1100, 2'b11, 2, 3, 4)); // phase 1
        tab2.push_back(mk(8'h00, 0, 8'b0000_0000, 2'b00, 0, 0, 4)); // idle

        load_payload();

        // ---- reset state ----
        req_valid = 8'hFF;
        #3;
        chk("reset grant", 64'(grant), 64'(0));
        chk("reset cdb_valid", 64'(cdb_valid), 64'(0));
        chk("reset rr_ptr", 64'(rr_ptr), 64'(0));
        chk("reset cdb_prn", 64'(cdb_prn), 64'(0));
        req_valid = '0;
        #9 reset_n = 1'b1;           // released at t=12, away from edges
        @(posedge clock); #1;

        foreach (tab1[i]) run_vec(tab1[i], $sformatf("t1[%0d]", i));

        // ---- reset mid-stream ----
        req_valid = 8'b0000_0011;
        #1;
        chk("mid grant", 64'(grant), 64'(8'b0000_0011));
        @(posedge clock); #1;
        chk("mid cdb_valid", 64'(cdb_valid), 64'(2'b11));
        chk("mid rr_ptr", 64'(rr_ptr), 64'(2));
        reset_n = 1'b0;
        #1;
        chk("async cdb_valid", 64'(cdb_valid), 64'(0));
        chk("async rr_ptr", 64'(rr_ptr), 64'(0));
        chk("async grant", 64'(grant), 64'(0));
        @(posedge clock); #1;
        chk("held cdb_valid", 64'(cdb_valid), 64'(0));
        chk("held grant", 64'(grant), 64'(0));
        req_valid = '0;
        #2 reset_n = 1'b1;
        @(posedge clock); #1;

        foreach (tab2[i]) run_vec(tab2[i], $sformatf("t2[%0d]", i));

        // ---- single streamer, back-to-back on requester 5 ----
        for (int c = 0; c < 6; c++) begin
            req_valid = 8'b0010_0000;
            req_value[5*DW +: DW] = 32'h100 + c;
            #1;
            chk($sformatf("strm%0d grant", c), 64'(grant), 64'(8'b0010_0000));
            @(posedge clock); #1;
            chk($sformatf("strm%0d cdb_valid", c), 64'(cdb_valid), 64'(2'b01));
            chk($sformatf("strm%0d src0", c), 64'(cdb_src[0 +: SW]), 64'(5));
            chk($sformatf("strm%0d value0", c), 64'(cdb_value[0 +: DW]), 64'(32'h100 + c));
            chk($sformatf("strm%0d rr_ptr", c), 64'(rr_ptr), 64'(6));
        end
        req_valid = '0;
        @(posedge clock); #1;
        chk("post strm cdb_valid", 64'(cdb_valid), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
